// File: rtl/multiword_add_seq.sv
// multiword_add_seq: streams a WORDS*N-bit addition through one N-bit adder, LSW first.
// Optional `MWADD_OVF_EN adds o_out_ovf, the signed overflow of the whole operation.
module multiword_add_seq #(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [N-1:0] i_in_a,
    input  logic [N-1:0] i_in_b,
    input  logic         i_op_cin,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [N-1:0] o_out_sum,
    output logic         o_out_last,
    output logic         o_out_cout
`ifdef MWADD_OVF_EN
   ,output logic         o_out_ovf
`endif
);
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic          r_valid;
    logic [N-1:0]  r_sum;
    logic          r_last;
    logic          r_cout;
    logic          w_accept;
    logic          w_first;
    logic          w_last;
    logic          w_cin;
    logic          w_cout;
    logic [N-1:0]  w_sum;

    // One-deep output register: a new word may enter whenever the current one leaves.
    assign o_in_ready = !r_valid || i_out_ready;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_first    = (r_cnt == '0);
    assign w_last     = (r_cnt == CW'(WORDS - 1));
    // Each operation starts from its own carry-in; later beats chain the stored carry.
    assign w_cin      = w_first ? i_op_cin : r_carry;
    assign {w_cout, w_sum} = {1'b0, i_in_a} + {1'b0, i_in_b} + {{N{1'b0}}, w_cin};

    // Beat position and inter-beat carry advance only on an accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
            r_carry <= w_cout;
        end
    end

    // Output word register; holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_last  <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_sum   <= w_sum;
            r_last  <= w_last;
            r_cout  <= w_last && w_cout;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_valid;
    assign o_out_sum   = r_sum;
    assign o_out_last  = r_last;
    assign o_out_cout  = r_cout;

`ifdef MWADD_OVF_EN
    logic r_ovf;
    logic w_ovf;

    // Signed overflow only makes sense on the most-significant word.
    assign w_ovf = w_last && (i_in_a[N-1] == i_in_b[N-1]) && (w_sum[N-1] != i_in_a[N-1]);

    // Overflow flag travels with the sum word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= w_ovf;
        end
    end

    assign o_out_ovf = r_ovf;
`endif
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: directed bench with a whole-operation arithmetic model for multiword_add_seq.
module tb_multiword_add_seq;
    localparam int N = 8;
    localparam int W = 4;

    typedef struct packed {
        logic [N-1:0] s;
        logic         l;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_in_valid = 1'b0;
    logic         i_op_cin = 1'b0;
    logic         i_out_ready = 1'b1;
    logic [N-1:0] i_in_a = '0;
    logic [N-1:0] i_in_b = '0;
    logic         o_in_ready;
    logic         o_out_valid;
    logic [N-1:0] o_out_sum;
    logic         o_out_last;
    logic         o_out_cout;
    logic         o_out_ovf;
    exp_t         cur;
    exp_t         q[$];
    exp_t         lg[$];
    int           tests = 0;
    int           fails = 0;
    logic         pv = 1'b0;
    logic         pr = 1'b0;
    exp_t         pout;

    always #5 clk = ~clk;

    multiword_add_seq #(.N(N), .WORDS(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .i_in_a     (i_in_a),
        .i_in_b     (i_in_b),
        .i_op_cin   (i_op_cin),
        .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready),
        .o_out_sum  (o_out_sum),
        .o_out_last (o_out_last),
        .o_out_cout (o_out_cout)
`ifdef MWADD_OVF_EN
       ,.o_out_ovf  (o_out_ovf)
`endif
    );

`ifndef MWADD_OVF_EN
    assign o_out_ovf = 1'b0;
`endif

    assign cur = {o_out_sum, o_out_last, o_out_cout, o_out_ovf};

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model: add the full 32-bit operands at once, then slice the result into LSW-first words.
    task automatic push_op(logic [31:0] a, logic [31:0] b, logic cin, int nb);
        logic [32:0] f;
        exp_t e;
        f = {1'b0, a} + {1'b0, b} + 33'(cin);
        for (int i = 0; i < nb; i++) begin
            e.s = f[8*i +: 8];
            e.l = (i == W - 1);
            e.c = (i == W - 1) && f[32];
            e.v = (i == W - 1) && (a[31] == b[31]) && (f[31] != a[31]);
            q.push_back(e);
        end
    endtask

    task automatic send_beat(logic [N-1:0] a, logic [N-1:0] b, logic cin, int gap);
        int t;
        i_in_a = a;
        i_in_b = b;
        i_op_cin = cin;
        i_in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!o_in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (t >= 100) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        if (gap > 0) begin
            i_in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // op_cin is driven inverted on non-first beats to show it is ignored there.
    task automatic send_op(logic [31:0] a, logic [31:0] b, logic cin, int gap, int nb);
        push_op(a, b, cin, nb);
        for (int i = 0; i < nb; i++)
            send_beat(a[8*i +: 8], b[8*i +: 8], (i == 0) ? cin : ~cin, gap);
    endtask

    task automatic idle();
        i_in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic take(output logic [31:0] s, output logic [3:0] l, output logic [3:0] c, output logic [3:0] v);
        exp_t e;
        s = '0; l = '0; c = '0; v = '0;
        chk("log_size", lg.size() >= W, 1);
        for (int i = 0; i < W; i++) begin
            if (lg.size() > 0) begin
                e = lg.pop_front();
                s[8*i +: 8] = e.s;
                l[i] = e.l;
                c[i] = e.c;
                v[i] = e.v;
            end
        end
    endtask

    // Compare process: every transferred word must match the model; stalls must hold outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_out", {o_out_valid, cur}, 0);
            chk("reset_in_ready", o_in_ready, 1);
            pv = 1'b0;
        end else begin
            if (pv && !pr) chk("stall_hold", {o_out_valid, cur}, {1'b1, pout});
            chk("in_ready", o_in_ready, !o_out_valid || i_out_ready);
            if (o_out_valid && i_out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", cur, 0);
                end else begin
                    chk("stream", cur, q.pop_front());
                    lg.push_back(cur);
                end
            end
            pv = o_out_valid;
            pr = i_out_ready;
            pout = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic [3:0]  l, c, v;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Carry ripples across three words.
        send_op(32'h01FFFFFF, 32'h00000001, 1'b0, 0, W);
        idle();
        take(s, l, c, v);
        chk("s1_sum", s, 32'h02000000);
        chk("s1_last", l, 4'b1000);
        chk("s1_cout", c, 4'b0000);

        // Full wrap then a zero op back-to-back: no carry leak.
        send_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 0, W);
        send_op(32'h00000000, 32'h00000000, 1'b0, 0, W);
        idle();
        take(s, l, c, v);
        chk("s2a_sum", s, 32'h00000000);
        chk("s2a_cout", c, 4'b1000);
        take(s, l, c, v);
        chk("s2b_sum", s, 32'h00000000);
        chk("s2b_cout", c, 4'b0000);
        chk("s2b_last", l, 4'b1000);

        // Backpressure for 3 cycles after beat 2.
        push_op(32'h01FFFFFF, 32'h00000001, 1'b0, W);
        send_beat(8'hFF, 8'h01, 1'b0, 0);
        send_beat(8'hFF, 8'h00, 1'b1, 0);
        i_out_ready = 1'b0;
        i_in_a = 8'hFF;
        i_in_b = 8'h00;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", o_in_ready, 0);
            chk("bp_valid_sum", {o_out_valid, o_out_sum}, {1'b1, 8'h00});
        end
        @(posedge clk);
        #1;
        i_out_ready = 1'b1;
        send_beat(8'hFF, 8'h00, 1'b1, 0);
        send_beat(8'h01, 8'h00, 1'b1, 0);
        idle();
        take(s, l, c, v);
        chk("s3_sum", s, 32'h02000000);
        chk("s3_last", l, 4'b1000);
        chk("s3_count", lg.size(), 0);

        // Input gaps between every beat.
        send_op(32'h01FFFFFF, 32'h00000001, 1'b0, 2, W);
        idle();
        take(s, l, c, v);
        chk("s4_sum", s, 32'h02000000);
        chk("s4_last", l, 4'b1000);
        chk("s4_cout", c, 4'b0000);

        // Reset after beat 2 with a pending carry, then a fresh op.
        send_op(32'h01FFFFFF, 32'h00000001, 1'b0, 0, 2);
        i_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("s5_partial", lg.size(), 2);
        lg.delete();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_op(32'h00000003, 32'h00000004, 1'b0, 0, W);
        idle();
        take(s, l, c, v);
        chk("s5_sum", s, 32'h00000007);
        chk("s5_last", l, 4'b1000);
        chk("s5_cout", c, 4'b0000);

`ifdef MWADD_OVF_EN
        send_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, W);
        send_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, W);
        idle();
        take(s, l, c, v);
        chk("ovf1_msw", s[31:24], 8'h80);
        chk("ovf1_ovf", v, 4'b1000);
        chk("ovf1_cout", c, 4'b0000);
        take(s, l, c, v);
        chk("ovf2_ovf", v, 4'b0000);
        chk("ovf2_cout", c, 4'b1000);
`endif

        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequential multi-word adder that adds two WORDS×N-bit operands as a stream of N-bit words, least-significant word first, one word per cycle. It is the stage that drives the N-bit ripple-carry adder: it presents `a`, `b` and `cin` each beat, registers `sum`, and chains `cout` into the next beat through a carry register. The result streams out with a valid/ready handshake, so wide additions (for example 128-bit with N=32) reuse one N-bit adder instance.

## Interface
- `N`, 32, word width; the width of the instantiated adder.
- `WORDS`, 4, words per operation; must be ≥1.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  the input word is valid.
- `in_ready`  out  1  the block accepts the word when `in_valid && in_ready`.
- `in_a`  in  N  operand A word.
- `in_b`  in  N  operand B word.
- `op_cin`  in  1  carry-in for the operation; sampled only on the first beat.
- `out_valid`  out  1  the output word is valid.
- `out_ready`  in  1  downstream accepts the output word.
- `out_sum`  out  N  sum word.
- `out_last`  out  1  marks the final (most-significant) word of the operation.
- `out_cout`  out  1  final carry-out; meaningful only when `out_last` is 1, and 0 otherwise.

## Operation
- Beat counter `cnt`, width `$clog2(WORDS)` (minimum 1), plus a carry register `carry_q`.
- States are implied by `cnt`:
  - FIRST (`cnt==0`): the adder's `cin` is `op_cin`.
  - MID/LAST (`cnt>0`): the adder's `cin` is `carry_q`.
- On input accept:
  - `carry_q` ← adder `cout`.
  - `out_sum` ← adder `sum`.
  - `out_last` ← (`cnt==WORDS-1`).
  - `out_cout` ← adder `cout` if the beat is last, else 0.
  - `cnt` ← 0 if the beat is last, else `cnt+1`.
- Wrap-around: after the last beat, `cnt` returns to 0. The next operation uses its own `op_cin`, never the previous `carry_q`.
- `WORDS==1`: every beat is both first and last.
- Output register is one deep: `in_ready = !out_valid || out_ready`. There is no combinational path from `in_valid` to `out_valid`.
- `out_valid` is set on input accept. It is cleared when `out_ready` is high and there is no accept in the same cycle.
- Simultaneous output drain and input accept: the register reloads and `out_valid` stays 1.
- While stalled (`out_valid && !out_ready`), all outputs hold stable and `cnt`/`carry_q` do not change.
- Upstream may deassert `in_valid` between beats of one operation. State is held until the next beat arrives, with no timeout.

## Timing
- Latency is 1 cycle: the word accepted at edge k is on `out_sum` with `out_valid=1` after edge k.
- Throughput is 1 word/cycle with `out_ready` held high; one operation takes WORDS cycles, back-to-back with no bubble.
- The critical path is the N-bit ripple (carry mux → adder → output register). There is no pipelining inside a beat.
- Reset values:
  - `out_valid=0`, `out_sum=0`, `out_last=0`, `out_cout=0`.
  - `cnt=0`, `carry_q=0`.
  - `in_ready=1` from the first cycle after reset.
- Reset asserted mid-operation discards the partial operation. The first accepted beat after reset is treated as FIRST.

## Configuration
- `MWADD_OVF_EN` defined: adds output port `out_ovf` (1 bit, resets to 0). It is the two's-complement overflow of the whole operation, computed on the last beat as `(a[N-1]==b[N-1]) && (sum[N-1]!=a[N-1])` and registered with `out_sum`. It is 0 on non-last beats.
- `MWADD_OVF_EN` undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
All scenarios use N=8, WORDS=4, words given LSW first.
- Carry propagation: A=0x01FFFFFF (FF,FF,FF,01), B=0x00000001 (01,00,00,00), `op_cin=0` → sums 00,00,00,02; `out_last` only on beat 4; `out_cout=0`.
- Full wrap: A=0xFFFFFFFF, B=0, `op_cin=1` → sums 00,00,00,00; `out_cout=1` with `out_last`. An immediately following op A=B=0, `op_cin=0` → all 00, `out_cout=0`, proving the carry does not leak between operations.
- Backpressure: as in scenario 1, with `out_ready=0` for 3 cycles after beat 2 → `in_ready=0`, `out_sum` held at 00 with `out_valid=1`; after release, beats 3–4 are 00,02 with no drops or duplicates.
- Input gaps: same as scenario 1 with `in_valid` low for 2 cycles between every beat → identical result stream.
- Reset mid-op: assert `rst_n=0` after beat 2, then send a fresh op A=0x00000003, B=0x00000004 → all outputs 0 during reset; result 07,00,00,00 with `out_last` on the 4th beat.
- With `MWADD_OVF_EN`: A=0x7FFFFFFF, B=0x00000001 → MSW 0x80, `out_ovf=1`, `out_cout=0`; A=0xFFFFFFFF, B=0x00000001 → `out_ovf=0`, `out_cout=1`.
